// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: registers ALU operands on accept, captures the ALU result one cycle later.
// Optional macro ALU_EXEC_STALL_CNT_EN adds a saturating stall_cnt output.
module alu_exec_ctrl #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opcode,
    input  logic [DW-1:0] in_rs,
    input  logic [DW-1:0] in_rt,
    input  logic [DW-1:0] in_imm,
    input  logic [DW-1:0] in_pc,
    input  logic [RW-1:0] in_rd,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_wb_en,
    output logic [RW-1:0] out_rd,
    output logic [DW-1:0] out_wb_data,
    output logic          out_br_taken,
    output logic [DW-1:0] out_br_target,
    output logic          out_err
`ifdef ALU_EXEC_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_EQ   = 3'd4;
    localparam logic [2:0] OP_LEU  = 3'd5;
    localparam logic [2:0] OP_NONE = 3'd7;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic accept;
    logic capture;

    logic [2:0]    dec_op;
    logic [DW-1:0] dec_a;
    logic [DW-1:0] dec_b;
    logic          dec_wb;
    logic          dec_br;
    logic          dec_err;

    logic          wb_q;
    logic          br_q;
    logic          err_q;
    logic [RW-1:0] rd_q;
    logic [DW-1:0] target_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Opcode decode: ALU selection plus the flags that decide how the result is used.
    always_comb begin
        dec_op  = OP_NONE;
        dec_a   = '0;
        dec_b   = '0;
        dec_wb  = 1'b0;
        dec_br  = 1'b0;
        dec_err = 1'b0;
        case (in_opcode)
            4'd0: begin dec_op = OP_ADD; dec_a = in_rs; dec_b = in_rt;  dec_wb = 1'b1; end
            4'd1: begin dec_op = OP_SUB; dec_a = in_rs; dec_b = in_rt;  dec_wb = 1'b1; end
            4'd2: begin dec_op = OP_AND; dec_a = in_rs; dec_b = in_rt;  dec_wb = 1'b1; end
            4'd3: begin dec_op = OP_OR;  dec_a = in_rs; dec_b = in_rt;  dec_wb = 1'b1; end
            4'd4: begin dec_op = OP_ADD; dec_a = in_rs; dec_b = in_imm; dec_wb = 1'b1; end
            4'd5: begin dec_op = OP_EQ;  dec_a = in_rs; dec_b = in_rt;  dec_br = 1'b1; end
            4'd6: begin dec_op = OP_LEU; dec_a = in_rs; dec_b = in_rt;  dec_br = 1'b1; end
            4'd7: begin dec_op = OP_NONE; end
            default: begin
                dec_op  = OP_NONE;
                dec_err = 1'b1;
            end
        endcase
    end

    // Downstream outputs only change on the capture edge, so they stay frozen through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op        <= OP_NONE;
            alu_a         <= '0;
            alu_b         <= '0;
            wb_q          <= 1'b0;
            br_q          <= 1'b0;
            err_q         <= 1'b0;
            rd_q          <= '0;
            target_q      <= '0;
            out_wb_en     <= 1'b0;
            out_rd        <= '0;
            out_wb_data   <= '0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            out_err       <= 1'b0;
        end else begin
            if (accept) begin
                alu_op   <= dec_op;
                alu_a    <= dec_a;
                alu_b    <= dec_b;
                wb_q     <= dec_wb;
                br_q     <= dec_br;
                err_q    <= dec_err;
                rd_q     <= in_rd;
                target_q <= in_pc + ONE + in_imm;
            end
            if (capture) begin
                out_wb_data   <= alu_result;
                out_wb_en     <= wb_q;
                out_br_taken  <= br_q & alu_zero;
                out_err       <= err_q;
                out_rd        <= rd_q;
                out_br_target <= target_q;
            end
        end
    end

`ifdef ALU_EXEC_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
